// File: rtl/training_epoch_sequencer_pkg.sv
// Shared definitions for the perceptron learning machine and its epoch
// sequencer: sample/weight widths and the sequencer state encoding.
package training_epoch_sequencer_pkg;

  localparam int X_W = 7;   // sample feature width
  localparam int T_W = 2;   // target label width
  localparam int W_W = 14;  // weight width inside the learning machine

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    WAIT_REQ,
    FETCH,
    EPOCH_END,
    DONE
  } seq_state_e;

endpackage

// File: rtl/training_epoch_sequencer_sample_addr_counter.sv
// Sample RAM address counter: counts 0..N_SAMPLES-1 and wraps to 0,
// flagging the last sample of an epoch.
module sample_addr_counter #(
  parameter int N_SAMPLES = 100,
  parameter int ADDR_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

  logic [ADDR_W-1:0] r_addr;

  assign o_addr = r_addr;
  assign o_last = (r_addr == LAST_ADDR);

  // Address register: clear wins over increment; wrap after the last sample.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order.
    if (!rst) begin
      r_addr <= '0;
    end else if (i_clear) begin
      r_addr <= '0;
    end else if (i_inc) begin
      r_addr <= o_last ? '0 : r_addr + 1'b1;
    end
  end

endmodule

// File: rtl/training_epoch_sequencer.sv
// Epoch sequencer for the perceptron learning machine. Feeds samples from
// the sample RAM on each machine request, counts epochs, and stops on a
// pass with no weight updates or at MAX_EPOCHS.
// The RAM read strobe and address are registered and issued in the FETCH
// cycle; the sample is captured at the end of FETCH, so data_valid follows
// mem_rd by one cycle and the machine's request by two.
// Optional watchdog: define SEQ_WATCHDOG_EN to end a stalled run with err=1.
module training_epoch_sequencer
  import training_epoch_sequencer_pkg::*;
#(
  parameter int N_SAMPLES  = 100,
  parameter int ADDR_W     = 7,
  parameter int MAX_EPOCHS = 50,
  parameter int EPOCH_W    = 8,
  parameter int WD_LIMIT   = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               abort,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [X_W-1:0]     mem_x1,
  input  logic [X_W-1:0]     mem_x2,
  input  logic [T_W-1:0]     mem_t,
  output logic               lm_start,
  input  logic               lm_read_en,
  input  logic               lm_ready,
  input  logic               upd_seen,
  output logic [X_W-1:0]     x1Data,
  output logic [X_W-1:0]     x2Data,
  output logic [T_W-1:0]     tData,
  output logic               data_valid,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [EPOCH_W-1:0] epoch_cnt,
  output logic               err
);

  localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(MAX_EPOCHS - 1);

  seq_state_e r_state, w_next;

  logic [ADDR_W-1:0]  w_addr;
  logic               w_last;
  logic               w_addr_clr, w_addr_inc;
  logic               w_issue_rd, w_capture, w_epoch_eval, w_start_run;
  logic               w_wd_expired, w_wd_fire;
  logic               w_any_upd, w_busy;

  logic               r_mem_rd;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [X_W-1:0]     r_x1, r_x2;
  logic [T_W-1:0]     r_t;
  logic               r_data_valid;
  logic               r_converged;
  logic [EPOCH_W-1:0] r_epoch_cnt;
  logic               r_any_upd;

  // The update seen in the evaluating cycle itself still counts.
  assign w_any_upd  = r_any_upd | upd_seen;
  assign w_busy     = (r_state != IDLE) && (r_state != DONE);
  assign w_addr_clr = abort | w_start_run;

  sample_addr_counter #(
    .N_SAMPLES (N_SAMPLES),
    .ADDR_W    (ADDR_W)
  ) u_addr_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_addr_clr),
    .i_inc   (w_addr_inc),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next state and per-cycle strobes; abort overrides every transition.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and infers a latch.
    w_next       = r_state;
    w_addr_inc   = 1'b0;
    w_issue_rd   = 1'b0;
    w_capture    = 1'b0;
    w_epoch_eval = 1'b0;
    w_start_run  = 1'b0;
    w_wd_fire    = 1'b0;
    if (abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (go) begin
            w_next      = KICK;
            w_start_run = 1'b1;
          end
        end
        KICK: w_next = WAIT_REQ;
        WAIT_REQ: begin
          if (lm_read_en) begin
            w_issue_rd = 1'b1;
            w_next     = FETCH;
          end else if (w_wd_expired) begin
            w_wd_fire = 1'b1;
            w_next    = DONE;
          end
        end
        FETCH: begin
          w_capture  = 1'b1;
          w_addr_inc = 1'b1;
          w_next     = w_last ? EPOCH_END : WAIT_REQ;
        end
        EPOCH_END: begin
          if (lm_read_en || lm_ready) begin
            w_epoch_eval = 1'b1;
            if (!w_any_upd || (r_epoch_cnt == EPOCH_LAST)) w_next = DONE;
            else                                          w_next = WAIT_REQ;
          end else if (w_wd_expired) begin
            w_wd_fire = 1'b1;
            w_next    = DONE;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // Datapath: RAM strobe, sample capture, epoch count and update tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem_rd     <= 1'b0;
      r_mem_addr   <= '0;
      r_x1         <= '0;
      r_x2         <= '0;
      r_t          <= '0;
      r_data_valid <= 1'b0;
      r_converged  <= 1'b0;
      r_epoch_cnt  <= '0;
      r_any_upd    <= 1'b0;
    end else begin
      r_mem_rd     <= w_issue_rd;
      r_data_valid <= w_capture;
      if (w_issue_rd) r_mem_addr <= w_addr;
      if (w_capture) begin
        r_x1 <= mem_x1;
        r_x2 <= mem_x2;
        r_t  <= mem_t;
      end
      if (w_start_run) begin
        r_epoch_cnt <= '0;
        r_any_upd   <= 1'b0;
        r_converged <= 1'b0;
      end else if (abort) begin
        r_any_upd   <= 1'b0;
        r_converged <= 1'b0;
      end else begin
        if (w_busy) r_any_upd <= w_any_upd;
        if (w_epoch_eval) begin
          if (r_epoch_cnt != '1) r_epoch_cnt <= r_epoch_cnt + 1'b1;
          if (w_next == DONE) r_converged <= ~w_any_upd;
          else                r_any_upd   <= 1'b0;
        end
      end
    end
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_CNT_W = $clog2(WD_LIMIT + 1);

  logic [WD_CNT_W-1:0] r_wd_cnt;
  logic                r_err;

  // Fires on the WD_LIMIT-th consecutive cycle spent waiting in one state.
  assign w_wd_expired = (r_wd_cnt == WD_CNT_W'(WD_LIMIT - 1));
  assign err          = r_err;

  // Watchdog counter restarts on any state change; err is sticky until go/abort.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_next != r_state)
        r_wd_cnt <= '0;
      else if ((r_state == WAIT_REQ) || (r_state == EPOCH_END))
        r_wd_cnt <= r_wd_cnt + 1'b1;
      if (w_start_run || abort) r_err <= 1'b0;
      else if (w_wd_fire)       r_err <= 1'b1;
    end
  end
`else
  assign w_wd_expired = 1'b0;
  assign err          = 1'b0;
`endif

  assign mem_rd     = r_mem_rd;
  assign mem_addr   = r_mem_addr;
  assign lm_start   = (r_state == KICK);
  assign x1Data     = r_x1;
  assign x2Data     = r_x2;
  assign tData      = r_t;
  assign data_valid = r_data_valid;
  assign busy       = w_busy;
  assign done       = (r_state == DONE);
  assign converged  = r_converged;
  assign epoch_cnt  = r_epoch_cnt;

endmodule

// File: tb/tb_training_epoch_sequencer.sv
// Directed bench for training_epoch_sequencer with a small epoch (4 samples)
// and a 3-epoch limit. The RAM is a combinational model of mem_addr; the
// learning machine is played by the directed steps below.
module tb_training_epoch_sequencer;
  import training_epoch_sequencer_pkg::*;

  localparam int N_SAMPLES  = 4;
  localparam int ADDR_W     = 7;
  localparam int MAX_EPOCHS = 3;
  localparam int EPOCH_W    = 8;
  localparam int WD_LIMIT   = 16;

  logic               clk = 1'b0;
  logic               rst, go, abort, lm_read_en, lm_ready, upd_seen;
  logic               mem_rd, lm_start, data_valid, busy, done, converged, err;
  logic [ADDR_W-1:0]  mem_addr;
  logic [X_W-1:0]     mem_x1, mem_x2, x1Data, x2Data;
  logic [T_W-1:0]     mem_t, tData;
  logic [EPOCH_W-1:0] epoch_cnt;

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [X_W-1:0] ram_x1(input int a);
    return X_W'(a + 10);
  endfunction
  function automatic logic [X_W-1:0] ram_x2(input int a);
    return X_W'(a * 3 + 1);
  endfunction
  function automatic logic [T_W-1:0] ram_t(input int a);
    return T_W'(a);
  endfunction

  assign mem_x1 = ram_x1(int'(mem_addr));
  assign mem_x2 = ram_x2(int'(mem_addr));
  assign mem_t  = ram_t(int'(mem_addr));

  // Counts every RAM read strobe the DUT issues.
  always @(posedge clk) if (rst && mem_rd) rd_cnt <= rd_cnt + 1;

  training_epoch_sequencer #(
    .N_SAMPLES (N_SAMPLES),
    .ADDR_W    (ADDR_W),
    .MAX_EPOCHS(MAX_EPOCHS),
    .EPOCH_W   (EPOCH_W),
    .WD_LIMIT  (WD_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort),
    .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_x1(mem_x1), .mem_x2(mem_x2), .mem_t(mem_t),
    .lm_start(lm_start), .lm_read_en(lm_read_en), .lm_ready(lm_ready),
    .upd_seen(upd_seen),
    .x1Data(x1Data), .x2Data(x2Data), .tData(tData),
    .data_valid(data_valid), .busy(busy), .done(done),
    .converged(converged), .epoch_cnt(epoch_cnt), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise a request, wait (bounded) for the read strobe, check the address,
  // then check the captured sample one cycle later. upd is driven during the
  // FETCH cycle. Leaves two idle cycles after data_valid.
  task automatic serve_sample(input int addr, input logic upd, output int steps);
    int  n;
    bit  seen;
    lm_read_en = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 6) begin
      step();
      upd_seen = 1'b0;
      n++;
      seen = (mem_rd === 1'b1);
    end
    steps = n;
    check("rd_seen", 32'(seen), 32'd1);
    lm_read_en = 1'b0;
    check("rd_addr", 32'(mem_addr), 32'(addr));
    upd_seen = upd;
    step();
    upd_seen = 1'b0;
    check("dv",   32'(data_valid), 32'd1);
    check("rd_off", 32'(mem_rd), 32'd0);
    check("x1",   32'(x1Data), 32'(ram_x1(addr)));
    check("x2",   32'(x2Data), 32'(ram_x2(addr)));
    check("t",    32'(tData),  32'(ram_t(addr)));
    step();
    check("dv_pulse", 32'(data_valid), 32'd0);
    step();
  endtask

  initial begin
    int s;
    int rd_base;

    rst = 1'b0; go = 1'b1; abort = 1'b0;
    lm_read_en = 1'b0; lm_ready = 1'b0; upd_seen = 1'b0;

    // Reset held 3 cycles with go high.
    step(); step(); step();
    check("rst_ctl",  32'({mem_rd, lm_start, data_valid, done, converged, err}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'({x1Data, x2Data, tData}), 32'd0);
    check("rst_epoch", 32'(epoch_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1; go = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Convergence: no updates in the first epoch.
    rd_base = rd_cnt;
    go = 1'b1;
    step();
    check("c_kick", 32'(lm_start), 32'd1);
    check("c_busy", 32'(busy), 32'd1);
    go = 1'b0;
    step();
    check("c_kick_pulse", 32'(lm_start), 32'd0);
    serve_sample(0, 1'b0, s);
    check("c_req_lat", 32'(s), 32'd1);
    serve_sample(1, 1'b0, s);
    serve_sample(2, 1'b0, s);
    serve_sample(3, 1'b0, s);
    check("c_epoch_end_busy", 32'({busy, done}), 32'b10);
    lm_ready = 1'b1;
    step();
    lm_ready = 1'b0;
    check("c_done", 32'(done), 32'd1);
    check("c_conv", 32'(converged), 32'd1);
    check("c_epochs", 32'(epoch_cnt), 32'd1);
    check("c_busy_done", 32'(busy), 32'd0);
    check("c_reads", 32'(rd_cnt - rd_base), 32'd4);

    // Epoch limit: an update every epoch, the last one during EPOCH_END.
    rd_base = rd_cnt;
    go = 1'b1;
    step();
    check("l_restart", 32'({lm_start, done, converged}), 32'b100);
    check("l_epoch_clr", 32'(epoch_cnt), 32'd0);
    go = 1'b0;
    step();
    serve_sample(0, 1'b0, s);
    serve_sample(1, 1'b1, s);
    serve_sample(2, 1'b0, s);
    serve_sample(3, 1'b0, s);
    serve_sample(0, 1'b0, s);
    check("l_req_from_end", 32'(s), 32'd2);
    check("l_epoch1", 32'(epoch_cnt), 32'd1);
    serve_sample(1, 1'b0, s);
    serve_sample(2, 1'b1, s);
    serve_sample(3, 1'b0, s);
    serve_sample(0, 1'b0, s);
    check("l_epoch2", 32'(epoch_cnt), 32'd2);
    serve_sample(1, 1'b0, s);
    serve_sample(2, 1'b0, s);
    serve_sample(3, 1'b0, s);
    upd_seen = 1'b1; lm_ready = 1'b1;
    step();
    upd_seen = 1'b0; lm_ready = 1'b0;
    check("l_done", 32'(done), 32'd1);
    check("l_conv", 32'(converged), 32'd0);
    check("l_epochs", 32'(epoch_cnt), 32'd3);
    check("l_reads", 32'(rd_cnt - rd_base), 32'd12);

    // Late update: only in the EPOCH_END cycle of epoch 1.
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    serve_sample(0, 1'b0, s);
    serve_sample(1, 1'b0, s);
    serve_sample(2, 1'b0, s);
    serve_sample(3, 1'b0, s);
    upd_seen = 1'b1;
    serve_sample(0, 1'b0, s);
    check("u_not_done", 32'({done, epoch_cnt}), 32'({1'b0, 8'd1}));
    serve_sample(1, 1'b0, s);
    serve_sample(2, 1'b0, s);
    serve_sample(3, 1'b0, s);
    lm_ready = 1'b1;
    step();
    lm_ready = 1'b0;
    check("u_done", 32'(done), 32'd1);
    check("u_conv", 32'(converged), 32'd1);
    check("u_epochs", 32'(epoch_cnt), 32'd2);

    // Abort in the FETCH cycle of address 2, then restart.
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    serve_sample(0, 1'b0, s);
    serve_sample(1, 1'b0, s);
    lm_read_en = 1'b1;
    step();
    lm_read_en = 1'b0;
    check("a_fetch2", 32'({mem_rd, mem_addr}), 32'({1'b1, 7'd2}));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("a_idle", 32'({busy, done, converged}), 32'd0);
    check("a_no_dv", 32'(data_valid), 32'd0);
    check("a_hold", 32'(x1Data), 32'(ram_x1(1)));
    go = 1'b1;
    step();
    go = 1'b0;
    check("a_kick", 32'(lm_start), 32'd1);
    check("a_epoch_clr", 32'(epoch_cnt), 32'd0);
    step();
    serve_sample(0, 1'b0, s);

    // Stall in WAIT_REQ with no request.
    abort = 1'b1;
    step();
    abort = 1'b0;
    go = 1'b1;
    step();
    go = 1'b0;
    step();
`ifdef SEQ_WATCHDOG_EN
    for (int i = 0; i < WD_LIMIT - 1; i++) step();
    check("w_still_wait", 32'({busy, err}), 32'b10);
    step();
    check("w_done", 32'(done), 32'd1);
    check("w_err", 32'(err), 32'd1);
    check("w_conv", 32'(converged), 32'd0);
    go = 1'b1;
    step();
    go = 1'b0;
    check("w_err_clr", 32'({err, lm_start}), 32'b01);
    step();
`else
    for (int i = 0; i < 100; i++) step();
    check("w_state", 32'(dut.r_state == WAIT_REQ), 32'd1);
    check("w_no_err", 32'({err, done, busy}), 32'b001);
`endif

    // Reset in the middle of a run clears everything.
    serve_sample(0, 1'b0, s);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("r_ctl", 32'({mem_rd, lm_start, data_valid, done, converged, err, busy}), 32'd0);
    check("r_data", 32'({x1Data, x2Data, tData}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
